// File: rtl/ram_scan_pkg.sv
// Shared defaults and types for the RAM scan system.
package ram_scan_pkg;

    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_DATA_W      = 4;
    localparam int DEF_DWELL       = 50000000;
    localparam int DEF_SYNC_STAGES = 2;

    // Read-pointer source selected by the synchronized scan enable.
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } scan_mode_e;

    // Map the synchronized scan-enable level onto a read mode.
    function automatic scan_mode_e mode_of(input logic scan_en_s);
        scan_mode_e mode;
        if (scan_en_s) begin
            mode = MODE_SCAN;
        end else begin
            mode = MODE_MANUAL;
        end
        return mode;
    endfunction

endpackage

// File: rtl/ram_sdp_rf.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the
// old word (read-first); the new word is visible one cycle later.
// The array itself is never reset; only the read register is.
module ram_sdp_rf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Commit a whole word per write; contents persist across reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; sampling before the write lands gives read-first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_scan_system.sv
// RAM with synchronized board inputs, edge-triggered writes and a
// manual or auto-scanning read pointer feeding the display layer.
module ram_scan_system
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DWELL       = DEF_DWELL,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              scan_en,
    input  logic [ADDR_W-1:0] man_addr,
    output logic [ADDR_W-1:0] wr_addr_q,
    output logic [DATA_W-1:0] wr_data_q,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    // All asynchronous inputs travel together through one chain. The
    // buses come from slow switches, so per-bit skew settles long before
    // the write strobe edge is acted on.
    localparam int IN_W  = 1 + ADDR_W + DATA_W + 1 + ADDR_W;
    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [IN_W-1:0]   w_async_in;
    logic [IN_W-1:0]   r_sync [SYNC_STAGES];

    logic              w_wr_req_s;
    logic [ADDR_W-1:0] w_wr_addr_s;
    logic [DATA_W-1:0] w_wr_data_s;
    logic              w_scan_en_s;
    logic [ADDR_W-1:0] w_man_addr_s;

    logic              r_wr_req_d;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr_c;
    logic [DATA_W-1:0] r_wr_data_c;
    logic              r_wr_ack;

    scan_mode_e        w_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_valid_arm;
    logic              r_rd_valid;
    logic [DATA_W-1:0] w_ram_q;

    assign w_async_in = {wr_req, wr_addr, wr_data, scan_en, man_addr};
    assign {w_wr_req_s, w_wr_addr_s, w_wr_data_s, w_scan_en_s, w_man_addr_s} =
        r_sync[SYNC_STAGES-1];

    // Synchronizer chain for every board input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Rising-edge detect on the write strobe; the captured address/data
    // are committed on the following edge and acknowledged after that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_req_d  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr_c <= '0;
            r_wr_data_c <= '0;
            r_wr_ack    <= 1'b0;
        end else begin
            r_wr_req_d  <= w_wr_req_s;
            r_wr_en     <= w_wr_req_s & ~r_wr_req_d;
            r_wr_addr_c <= w_wr_addr_s;
            r_wr_data_c <= w_wr_data_s;
            r_wr_ack    <= r_wr_en;
        end
    end

    assign w_mode = mode_of(w_scan_en_s);

    // Next read pointer and dwell counter for manual and scan modes.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        case (w_mode)
            MODE_MANUAL: begin
                w_ptr_nxt = w_man_addr_s;
                w_cnt_nxt = '0;
            end
            MODE_SCAN: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_ptr_nxt = r_ptr;
                end
            end
            default: begin
                w_ptr_nxt = r_ptr;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Read pointer, dwell counter, aligned read address and valid flag.
    // rd_valid rises on the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_valid_arm <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd_addr   <= r_ptr;
            r_valid_arm <= 1'b1;
            r_rd_valid  <= r_valid_arm;
        end
    end

    ram_sdp_rf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (r_wr_en),
        .i_waddr (r_wr_addr_c),
        .i_wdata (r_wr_data_c),
        .i_raddr (r_ptr),
        .o_rdata (w_ram_q)
    );

    assign wr_addr_q = w_wr_addr_s;
    assign wr_data_q = w_wr_data_s;
    assign wr_ack    = r_wr_ack;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = w_ram_q;
    assign rd_valid  = r_rd_valid;

endmodule
